// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the
// set-associative write-through cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_e;

  localparam int OFFSET_BITS = 2;

  function automatic int tag_bits(
    input int width,
    input int set_bits
  );
    return width - set_bits - OFFSET_BITS;
  endfunction

  function automatic int set_lsb();
    return OFFSET_BITS;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// Age-based LRU update for one set: accessed way becomes
// youngest, ways younger than its old age shift down by one.
module lru_age_update #(
  parameter int WAYS = 4
) (
  input  logic [WAYS-1:0][$clog2(WAYS)-1:0] ages_i,
  input  logic [$clog2(WAYS)-1:0]           way_i,
  output logic [WAYS-1:0][$clog2(WAYS)-1:0] ages_o
);

  localparam int AW = $clog2(WAYS);

  logic [AW-1:0] old_age;

  // Promote accessed way, age the ones that were younger
  always_comb begin
    old_age = ages_i[way_i];
    ages_o  = ages_i;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == way_i) begin
        ages_o[w] = AW'(WAYS - 1);
      end else if (ages_i[w] > old_age) begin
        ages_o[w] = ages_i[w] - AW'(1);
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Set-associative, write-through, no-write-allocate cache
// with zero-latency read hits and age-based LRU.
module assoc_cache
  import cache_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SET_BITS = 4,
  parameter int WAYS     = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             ready_o,
  output logic             hit_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             mem_ack_i
);

  localparam int SETS = 2 ** SET_BITS;
  localparam int TW   = tag_bits(WIDTH, SET_BITS);
  localparam int AW   = $clog2(WAYS);
  localparam int SLSB = set_lsb();

  typedef logic [WAYS-1:0][AW-1:0] ages_t;

  state_e state_q, state_d;

  logic [WIDTH-1:0] data_q  [SETS][WAYS];
  logic [TW-1:0]    tag_q   [SETS][WAYS];
  logic [WAYS-1:0]  valid_q [SETS];
  ages_t            age_q   [SETS];

  logic [TW-1:0]       tag;
  logic [SET_BITS-1:0] set;
  logic [1:0]          unused_off;

  logic [WAYS-1:0] hit_vec;
  logic            any_hit;
  logic [AW-1:0]   hit_way;
  logic [AW-1:0]   victim;
  logic [AW-1:0]   acc_way;
  ages_t           ages_new;

  logic fill_en;
  logic wr_en;
  logic age_en;

  assign tag = addr_i[WIDTH-1:SET_BITS+SLSB];
  assign set = addr_i[SET_BITS+SLSB-1:SLSB];
  assign unused_off = addr_i[1:0];

  // Tag compare against every valid way of the set
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[set][w] &&
                   (tag_q[set][w] == tag);
    end
  end

  assign any_hit = |hit_vec;

  // Lowest hitting way; victim is lowest invalid else age 0
  always_comb begin
    hit_way = '0;
    victim  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit_way = AW'(w);
      end
      if (age_q[set][w] == '0) begin
        victim = AW'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[set][w]) begin
        victim = AW'(w);
      end
    end
  end

  assign acc_way = (state_q == FILL) ? victim : hit_way;

  lru_age_update #(
    .WAYS(WAYS)
  ) u_lru (
    .ages_i(age_q[set]),
    .way_i (acc_way),
    .ages_o(ages_new)
  );

  // Next state and CPU/memory handshake outputs
  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    hit_o       = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    rdata_o     = data_q[set][hit_way];
    mem_addr_o  = addr_i;
    mem_wdata_o = wdata_i;
    fill_en     = 1'b0;
    wr_en       = 1'b0;
    age_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          hit_o = any_hit;
          if (we_i) begin
            state_d = WRITE;
          end else if (any_hit) begin
            ready_o = 1'b1;
            age_en  = 1'b1;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          rdata_o = mem_rdata_i;
          ready_o = req_i;
          fill_en = 1'b1;
          age_en  = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ack_i) begin
          ready_o = req_i;
          state_d = IDLE;
          if (any_hit) begin
            wr_en  = 1'b1;
            age_en = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) begin
      state_d   = IDLE;
      ready_o   = 1'b0;
      hit_o     = 1'b0;
      mem_req_o = 1'b0;
      mem_we_o  = 1'b0;
      fill_en   = 1'b0;
      wr_en     = 1'b0;
      age_en    = 1'b0;
    end
  end

  // State, valid bits and ages; reset restores identity ages
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= AW'(w);
        end
      end
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[set][victim] <= 1'b1;
      end
      if (age_en) begin
        age_q[set] <= ages_new;
      end
    end
  end

  // Data and tag storage; fills allocate, write hits update
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      data_q[set][victim] <= mem_rdata_i;
      tag_q[set][victim]  <= tag;
    end else if (wr_en) begin
      data_q[set][hit_way] <= wdata_i;
    end
  end

endmodule

// File: tb/tb_assoc_cache.sv
// Directed-vector and random scoreboard bench for
// assoc_cache at 2, 4 and 8 ways.
module tb_assoc_cache;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mrdata;
  logic        ack;
  int          sel;

  logic [31:0] rd4, rd2, rd8;
  logic        rdy4, rdy2, rdy8;
  logic        hit4, hit2, hit8;
  logic        mq4, mq2, mq8;
  logic        mw4, mw2, mw8;
  logic [31:0] ma4, ma2, ma8;
  logic [31:0] md4, md2, md8;

  logic [31:0] rdata;
  logic        rdy;
  logic        hit;
  logic        mreq;
  logic        mwe;
  logic [31:0] maddr;
  logic [31:0] mwdata;

  logic [31:0] mem [logic [31:0]];

  int chk_cnt = 0;
  int pass_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assoc_cache #(.WIDTH(32), .SET_BITS(4), .WAYS(4)) u4 (
    .clk_i(clk), .rst_i(rst),
    .req_i(req && sel == 0), .we_i(we),
    .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rd4), .ready_o(rdy4), .hit_o(hit4),
    .mem_req_o(mq4), .mem_we_o(mw4),
    .mem_addr_o(ma4), .mem_wdata_o(md4),
    .mem_rdata_i(mrdata), .mem_ack_i(ack && sel == 0)
  );

  assoc_cache #(.WIDTH(32), .SET_BITS(4), .WAYS(2)) u2 (
    .clk_i(clk), .rst_i(rst),
    .req_i(req && sel == 1), .we_i(we),
    .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rd2), .ready_o(rdy2), .hit_o(hit2),
    .mem_req_o(mq2), .mem_we_o(mw2),
    .mem_addr_o(ma2), .mem_wdata_o(md2),
    .mem_rdata_i(mrdata), .mem_ack_i(ack && sel == 1)
  );

  assoc_cache #(.WIDTH(32), .SET_BITS(4), .WAYS(8)) u8 (
    .clk_i(clk), .rst_i(rst),
    .req_i(req && sel == 2), .we_i(we),
    .addr_i(addr), .wdata_i(wdata),
    .rdata_o(rd8), .ready_o(rdy8), .hit_o(hit8),
    .mem_req_o(mq8), .mem_we_o(mw8),
    .mem_addr_o(ma8), .mem_wdata_o(md8),
    .mem_rdata_i(mrdata), .mem_ack_i(ack && sel == 2)
  );

  always_comb begin
    rdata = rd4; rdy = rdy4; hit = hit4;
    mreq = mq4; mwe = mw4; maddr = ma4; mwdata = md4;
    if (sel == 1) begin
      rdata = rd2; rdy = rdy2; hit = hit2;
      mreq = mq2; mwe = mw2; maddr = ma2; mwdata = md2;
    end else if (sel == 2) begin
      rdata = rd8; rdy = rdy8; hit = hit8;
      mreq = mq8; mwe = mw8; maddr = ma8; mwdata = md8;
    end
  end

  task automatic check(
    input string nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic do_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic xact(
    input  bit          w,
    input  logic [31:0] a,
    input  logic [31:0] d,
    input  int          lat,
    output logic [31:0] rd,
    output bit          hit0,
    output bit          mseen,
    output bit          mwe0,
    output logic [31:0] maddr0,
    output logic [31:0] mwd0,
    output int          rcyc
  );
    int cnt;
    cnt = 0; rcyc = -1; rd = '0; hit0 = 0;
    mseen = 0; mwe0 = 0; maddr0 = '0; mwd0 = '0;
    req = 1'b1; we = w; addr = a; wdata = d; ack = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mreq) begin
        if (!mseen) begin
          mwe0 = mwe; maddr0 = maddr; mwd0 = mwdata;
        end
        mseen = 1;
        if (cnt == lat) begin
          ack = 1'b1;
          if (mwe) mem[maddr] = mwdata;
          else mrdata = memval(maddr);
        end
        cnt++;
      end
      #1;
      if (c == 0) hit0 = hit;
      if (rdy) begin
        rd = rdata;
        rcyc = c;
      end
      @(posedge clk); #1;
      ack = 1'b0;
      if (rcyc >= 0) break;
    end
    req = 1'b0; we = 1'b0;
  endtask

  task automatic chk_perm(input string nm);
    logic [7:0] mask;
    logic [7:0] full;
    int nw;
    bit ok;
    ok = 1;
    nw = (sel == 0) ? 4 : (sel == 1) ? 2 : 8;
    full = 8'((1 << nw) - 1);
    for (int s = 0; s < 16; s++) begin
      mask = '0;
      for (int w = 0; w < nw; w++) begin
        if (sel == 0) mask[u4.age_q[s][w]] = 1'b1;
        else if (sel == 1) mask[u2.age_q[s][w]] = 1'b1;
        else mask[u8.age_q[s][w]] = 1'b1;
      end
      if (mask != full) ok = 0;
    end
    check(nm, 32'(ok), 32'd1);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    bit          hit;
    logic [31:0] rd;
    bit          mreq;
    int          rcyc;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] rd_v, ma_v, mwd_v, expv, a_v;
    bit          h_v, ms_v, mwe_v, ok, w_v;
    int          rc_v, nw;

    rst = 1'b1; req = 1'b1; we = 1'b0; ack = 1'b0;
    addr = '0; wdata = '0; mrdata = '0; sel = 0;

    mem[32'h000] = 32'h1111_0000;
    mem[32'h040] = 32'hDEAD_BEEF;
    mem[32'h080] = 32'h2222_0080;
    mem[32'h0C0] = 32'h3333_00C0;
    mem[32'h100] = 32'h4444_0100;
    mem[32'h200] = 32'h5555_0200;

    vecs[0]  = '{0, 32'h040, 0, 3, 0, 32'hDEAD_BEEF, 1, 4};
    vecs[1]  = '{0, 32'h040, 0, 0, 1, 32'hDEAD_BEEF, 0, 0};
    vecs[2]  = '{0, 32'h000, 0, 1, 0, 32'h1111_0000, 1, 2};
    vecs[3]  = '{0, 32'h040, 0, 0, 1, 32'hDEAD_BEEF, 0, 0};
    vecs[4]  = '{0, 32'h080, 0, 0, 0, 32'h2222_0080, 1, 1};
    vecs[5]  = '{0, 32'h0C0, 0, 2, 0, 32'h3333_00C0, 1, 3};
    vecs[6]  = '{0, 32'h100, 0, 0, 0, 32'h4444_0100, 1, 1};
    vecs[7]  = '{0, 32'h040, 0, 0, 1, 32'hDEAD_BEEF, 0, 0};
    vecs[8]  = '{0, 32'h000, 0, 0, 0, 32'h1111_0000, 1, 1};
    vecs[9]  = '{0, 32'h0C0, 0, 0, 1, 32'h3333_00C0, 0, 0};
    vecs[10] = '{1, 32'h040, 32'h1234_5678, 1, 1, 0, 1, 2};
    vecs[11] = '{0, 32'h040, 0, 0, 1, 32'h1234_5678, 0, 0};
    vecs[12] = '{1, 32'h200, 32'hCAFE_0200, 0, 0, 0, 1, 1};
    vecs[13] = '{0, 32'h200, 0, 1, 0, 32'hCAFE_0200, 1, 2};
    vecs[14] = '{0, 32'h200, 0, 0, 1, 32'hCAFE_0200, 0, 0};

    @(posedge clk); @(negedge clk);
    check("rst_ready", 32'(rdy), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_mreq", 32'(mreq), 0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(rdy), 0);
    check("idle_mreq", 32'(mreq), 0);
    chk_perm("rst_ages");
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      xact(vecs[i].we, vecs[i].addr, vecs[i].wdata,
           vecs[i].lat, rd_v, h_v, ms_v, mwe_v,
           ma_v, mwd_v, rc_v);
      check($sformatf("v%0d_cyc", i), rc_v, vecs[i].rcyc);
      check($sformatf("v%0d_hit", i), 32'(h_v),
            32'(vecs[i].hit));
      check($sformatf("v%0d_mreq", i), 32'(ms_v),
            32'(vecs[i].mreq));
      if (!vecs[i].we)
        check($sformatf("v%0d_rd", i), rd_v, vecs[i].rd);
      if (vecs[i].mreq) begin
        check($sformatf("v%0d_maddr", i), ma_v,
              vecs[i].addr);
        check($sformatf("v%0d_mwe", i), 32'(mwe_v),
              32'(vecs[i].we));
        if (vecs[i].we)
          check($sformatf("v%0d_mwd", i), mwd_v,
                vecs[i].wdata);
      end
    end
    chk_perm("dir_ages");

    // reset during FILL, then a stray ack
    req = 1'b1; we = 1'b0; addr = 32'h300;
    @(negedge clk);
    check("fl_idle_miss_ready", 32'(rdy), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fl_mreq", 32'(mreq), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("fl_rst_ready", 32'(rdy), 0);
    check("fl_rst_mreq", 32'(mreq), 0);
    check("fl_rst_mwe", 32'(mwe), 0);
    @(posedge clk); #1;
    rst = 1'b0; req = 1'b0;
    ack = 1'b1; mrdata = 32'hBAD0_BAD0;
    @(negedge clk);
    check("fl_late_ready", 32'(rdy), 0);
    check("fl_late_mreq", 32'(mreq), 0);
    @(posedge clk); #1;
    ack = 1'b0;
    ok = 1;
    for (int s = 0; s < 16; s++) begin
      if (u4.valid_q[s] != 4'b0) ok = 0;
      for (int w = 0; w < 4; w++)
        if (u4.age_q[s][w] != 2'(w)) ok = 0;
    end
    check("fl_state_cleared", 32'(ok), 1);
    xact(0, 32'h300, 0, 0, rd_v, h_v, ms_v, mwe_v,
         ma_v, mwd_v, rc_v);
    check("fl_reread_hit", 32'(h_v), 0);
    check("fl_reread_rd", rd_v, 32'h5A5A_0300);
    xact(0, 32'h040, 0, 0, rd_v, h_v, ms_v, mwe_v,
         ma_v, mwd_v, rc_v);
    check("fl_040_hit", 32'(h_v), 0);
    check("fl_040_rd", rd_v, 32'h1234_5678);

    // random scoreboard on the 2-way and 8-way instances
    for (int k = 1; k <= 2; k++) begin
      sel = k;
      nw = (k == 1) ? 2 : 8;
      do_reset();
      for (int i = 0; i < 150; i++) begin
        a_v = (32'($urandom_range(0, nw + 1)) << 6) |
              (32'($urandom_range(0, 1)) << 2);
        w_v = ($urandom_range(0, 3) == 0);
        expv = memval(a_v);
        xact(w_v, a_v, $urandom, $urandom_range(0, 2),
             rd_v, h_v, ms_v, mwe_v, ma_v, mwd_v, rc_v);
        check("rnd_done", 32'(rc_v >= 0), 1);
        if (!w_v) check("rnd_rd", rd_v, expv);
        chk_perm("rnd_ages");
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
